// File: rtl/ex_mem_stage_if.sv
// Bundles the execute-side input bus, the memory-side output bus and the
// fetch redirect of the EX/MEM stage. slave is the stage itself; master is
// the surrounding pipeline (or a testbench standing in for it).
interface ex_mem_stage_if;
   // Execute-stage side
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [31:0] rs2_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        is_jalr;
   logic [2:0]  branch_type;
   logic        flush;

   // Memory-stage side
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_alu_res;
   logic [31:0] out_wb_data;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;

   // Fetch redirect
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport slave (
      input  in_valid, alu_res, alu_zero, pc, imm, rs2_data, rd,
             reg_write, mem_read, mem_write, is_jalr, branch_type, flush,
             out_ready,
      output in_ready, out_valid, out_alu_res, out_wb_data, out_store_data,
             out_rd, out_reg_write, out_mem_read, out_mem_write,
             redirect_valid, redirect_pc
   );

   modport master (
      output in_valid, alu_res, alu_zero, pc, imm, rs2_data, rd,
             reg_write, mem_read, mem_write, is_jalr, branch_type, flush,
             out_ready,
      input  in_ready, out_valid, out_alu_res, out_wb_data, out_store_data,
             out_rd, out_reg_write, out_mem_read, out_mem_write,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: resolves branches/jumps, issues a one-cycle fetch
// redirect for taken control flow, and carries the instruction payload to
// the memory stage through a 2-entry (main + skid) buffer so that in_ready
// never depends combinationally on out_ready.
module ex_mem_stage (
   input  logic            clk,
   input  logic            rst,
   ex_mem_stage_if.slave   bus
);

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] wb_data;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } entry_t;

   entry_t      r_main;
   entry_t      r_skid;
   logic        r_main_valid;
   logic        r_skid_valid;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   entry_t      w_new;
   logic        w_accept;
   logic        w_drain;
   logic        w_taken;
   logic [31:0] w_target;

   // A flushed input is never accepted, so it can neither fill an entry nor redirect.
   assign w_accept = bus.in_valid && !r_skid_valid && !bus.flush;
   assign w_drain  = r_main_valid && bus.out_ready;

   // Branch resolution and target/writeback selection for the offered instruction.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_taken = 1'b0;
      case (bus.branch_type)
         3'd1:    w_taken = bus.alu_zero;
         3'd2:    w_taken = !bus.alu_zero;
         3'd3,
         3'd5:    w_taken = bus.alu_res[0];
         3'd4,
         3'd6:    w_taken = !bus.alu_res[0];
         3'd7:    w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase

      w_target = bus.is_jalr ? (bus.alu_res & 32'hFFFF_FFFE) : (bus.pc + bus.imm);

      w_new.alu_res    = bus.alu_res;
      w_new.wb_data    = (bus.branch_type == 3'd7) ? (bus.pc + 32'd4) : bus.alu_res;
      w_new.store_data = bus.rs2_data;
      w_new.rd         = bus.rd;
      w_new.reg_write  = bus.reg_write;
      w_new.mem_read   = bus.mem_read;
      w_new.mem_write  = bus.mem_write;
   end

   // Main/skid buffer: strict FIFO, skid refills main on the edge main drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         // NOTE: payloads are reset too, so the out_* ports read zero during reset.
         r_main       <= '0;
         r_skid       <= '0;
      end else if (bus.flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_drain) begin
         if (r_skid_valid) begin
            // Skid full implies in_ready was low, so nothing new arrives this edge.
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main       <= w_new;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (!r_main_valid) begin
         if (w_accept) begin
            // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
            r_main       <= w_new;
            r_main_valid <= 1'b1;
         end
      end else if (w_accept) begin
         r_skid       <= w_new;
         r_skid_valid <= 1'b1;
      end
   end

   // One-cycle redirect for each accepted taken instruction, independent of out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_accept && w_taken;
         if (w_accept && w_taken) begin
            r_redirect_pc <= w_target;
         end
      end
   end

   assign bus.in_ready       = !r_skid_valid;
   assign bus.out_valid      = r_main_valid;
   assign bus.out_alu_res    = r_main.alu_res;
   assign bus.out_wb_data    = r_main.wb_data;
   assign bus.out_store_data = r_main.store_data;
   assign bus.out_rd         = r_main.rd;
   assign bus.out_mem_read   = r_main.mem_read;
   assign bus.out_reg_write  = r_main_valid && r_main.reg_write;
   assign bus.out_mem_write  = r_main_valid && r_main.mem_write;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: a scoreboard queue receives the
// expected memory-stage payload when an instruction is accepted and a
// negedge monitor pops/compares it when the stage delivers; redirects are
// predicted from the accepted instruction by an independent branch model.
module tb_ex_mem_stage;

   typedef struct packed {
      logic [2:0]  bt;
      logic [31:0] alu;
      logic        zero;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        jalr;
      logic [31:0] st;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } tx_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wb;
      logic [31:0] st;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   logic        acc_flag = 1'b0;
   tx_t         acc_tx   = '0;
   logic        rv_exp   = 1'b0;
   logic [31:0] rpc_exp  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic tx_t mk(input logic [2:0] bt, input logic [31:0] alu, input logic zero,
                              input logic [31:0] pc, input logic [31:0] imm, input logic jalr,
                              input logic [31:0] st, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw);
      tx_t t;
      t.bt = bt; t.alu = alu; t.zero = zero; t.pc = pc; t.imm = imm; t.jalr = jalr;
      t.st = st; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
      return t;
   endfunction

   // Branch model: beq/bne use the zero flag, compares use bit 0 of the ALU.
   function automatic logic m_taken(input tx_t t);
      if (t.bt == 3'd7) return 1'b1;
      if (t.bt == 3'd1) return t.zero;
      if (t.bt == 3'd2) return !t.zero;
      if (t.bt == 3'd3 || t.bt == 3'd5) return t.alu[0];
      if (t.bt == 3'd4 || t.bt == 3'd6) return !t.alu[0];
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_target(input tx_t t);
      if (t.jalr) return {t.alu[31:1], 1'b0};
      return t.pc + t.imm;
   endfunction

   function automatic exp_t m_out(input tx_t t);
      exp_t e;
      e.alu = t.alu;
      e.wb  = (t.bt == 3'd7) ? t.pc + 32'd4 : t.alu;
      e.st  = t.st; e.rd = t.rd; e.rw = t.rw; e.mr = t.mr; e.mw = t.mw;
      return e;
   endfunction

   task automatic drive(input tx_t t);
      bus.branch_type = t.bt;  bus.alu_res  = t.alu; bus.alu_zero  = t.zero;
      bus.pc          = t.pc;  bus.imm      = t.imm; bus.is_jalr   = t.jalr;
      bus.rs2_data    = t.st;  bus.rd       = t.rd;  bus.reg_write = t.rw;
      bus.mem_read    = t.mr;  bus.mem_write = t.mw;
   endtask

   // Offer t until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input tx_t t);
      drive(t);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(m_out(t));
            acc_tx   = t;
            acc_flag = 1'b1;
            @(posedge clk);
            #1;
            acc_flag     = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
      end
      check("send_timeout_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected redirect: the cycle after an accepted taken instruction.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_exp <= 1'b0;
      end else begin
         rv_exp <= acc_flag && m_taken(acc_tx);
         if (acc_flag && m_taken(acc_tx)) rpc_exp <= m_target(acc_tx);
      end
   end

   // Output monitor: redirect every cycle, scoreboard on each transfer.
   always @(negedge clk) begin
      exp_t e;
      check("redirect_valid", bus.redirect_valid, rv_exp);
      if (rv_exp) check("redirect_pc", bus.redirect_pc, rpc_exp);
      if (bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_alu_res",    bus.out_alu_res,    e.alu);
            check("out_wb_data",    bus.out_wb_data,    e.wb);
            check("out_store_data", bus.out_store_data, e.st);
            check("out_rd",         bus.out_rd,         e.rd);
            check("out_reg_write",  bus.out_reg_write,  e.rw);
            check("out_mem_read",   bus.out_mem_read,   e.mr);
            check("out_mem_write",  bus.out_mem_write,  e.mw);
         end
      end else if (!bus.out_valid) begin
         check("idle_mem_write", bus.out_mem_write, 0);
         check("idle_reg_write", bus.out_reg_write, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_t a, b, c;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      drive('0);

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_valid",      bus.out_valid,      0);
      check("rst_redirect_valid", bus.redirect_valid, 0);
      check("rst_redirect_pc",    bus.redirect_pc,    0);
      check("rst_out_alu_res",    bus.out_alu_res,    0);
      check("rst_out_wb_data",    bus.out_wb_data,    0);
      check("rst_out_store_data", bus.out_store_data, 0);
      check("rst_out_rd",         bus.out_rd,         0);
      rst = 1'b0;
      idle(1);
      check("post_rst_in_ready", bus.in_ready, 1);

      // beq taken: redirect 0x120, delivered next cycle
      bus.out_ready = 1'b1;
      send(mk(3'd1, 32'h0, 1'b1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      idle(3);

      // jal: wb=pc+4, target pc+imm; jalr: target alu with bit0 cleared
      send(mk(3'd7, 32'h1234, 1'b0, 32'h40, 32'h10, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0));
      idle(2);
      send(mk(3'd7, 32'h203, 1'b0, 32'h80, 32'h4, 1'b1, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0));
      idle(2);

      // Back-to-back taken (beq then bge) plus a store riding behind
      send(mk(3'd1, 32'h0, 1'b1, 32'h200, 32'h8, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      send(mk(3'd4, 32'h0, 1'b0, 32'h300, 32'hFFFF_FFF0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      send(mk(3'd0, 32'h1000, 1'b0, 32'h304, 32'h0, 1'b0, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1));
      idle(3);

      // bltu alu=1 taken, bgeu alu=1 not taken, consecutive
      send(mk(3'd5, 32'h1, 1'b0, 32'h400, 32'h40, 1'b0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0));
      send(mk(3'd6, 32'h1, 1'b0, 32'h404, 32'h40, 1'b0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0));
      idle(4);
      check("sb_drained_1", sb.size(), 0);

      // Backpressure: A main, B skid, C held upstream
      bus.out_ready = 1'b0;
      a = mk(3'd0, 32'hA, 1'b0, 32'h500, 32'h0, 1'b0, 32'h11, 5'd10, 1'b1, 1'b0, 1'b0);
      b = mk(3'd0, 32'hB, 1'b0, 32'h504, 32'h0, 1'b0, 32'h22, 5'd11, 1'b0, 1'b1, 1'b0);
      c = mk(3'd0, 32'hC, 1'b0, 32'h508, 32'h0, 1'b0, 32'h33, 5'd12, 1'b0, 1'b0, 1'b1);
      send(a);
      send(b);
      drive(c);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready_low",  bus.in_ready,    0);
      check("bp_out_valid",     bus.out_valid,   1);
      check("bp_main_is_a",     bus.out_alu_res, 32'hA);
      @(negedge clk);
      check("bp_still_blocked", bus.in_ready,    0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(c);
      idle(4);
      check("sb_drained_2", sb.size(), 0);

      // Flush with both entries full and a taken bne offered; pending redirect from B completes
      bus.out_ready = 1'b0;
      send(mk(3'd0, 32'hD0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0));
      send(mk(3'd1, 32'h0, 1'b1, 32'h604, 32'h100, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      drive(mk(3'd2, 32'h0, 1'b0, 32'h608, 32'h80, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_out_valid", bus.out_valid,      0);
      check("flush_in_ready",  bus.in_ready,       1);
      check("flush_no_redir",  bus.redirect_valid, 0);

      // Flush while empty with a jump offered: nothing accepted, no redirect
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drive(mk(3'd7, 32'h0, 1'b0, 32'h700, 32'h40, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0));
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_empty_out_valid", bus.out_valid,      0);
      check("flush_empty_no_redir",  bus.redirect_valid, 0);
      idle(2);

      // Asynchronous reset between edges with both entries full and a redirect pending
      bus.out_ready = 1'b0;
      send(mk(3'd0, 32'hE0, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0));
      send(mk(3'd1, 32'h0, 1'b1, 32'h804, 32'h20, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      #2;
      check("pre_rst_redir",    bus.redirect_valid, 1);
      check("pre_rst_in_ready", bus.in_ready,       0);
      rst = 1'b1;
      #1;
      check("arst_out_valid",   bus.out_valid,      0);
      check("arst_in_ready",    bus.in_ready,       1);
      check("arst_redir",       bus.redirect_valid, 0);
      check("arst_out_alu_res", bus.out_alu_res,    0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(mk(3'd3, 32'h1, 1'b0, 32'h900, 32'h30, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0));
      idle(4);
      check("sb_drained_3", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
